// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_arbiter
// Purpose  : Two-port (instruction fetch / data) arbiter in front of a
//            synchronous single-port SRAM. Grants are combinational. The SRAM
//            control, address and data outputs are registered. Reads return
//            on rdataN two cycles after the grant.
// Config   : `define SRAM_ARB_RR_EN -> round-robin tie break
//            (default build      -> fixed priority, port 1 wins ties)
// Revision : 1.0 - initial release
// ============================================================================
module sram_arbiter #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              CE_n,
  output logic              BWE_n,
  output logic [ADDR_W-1:0] A,
  output logic [DATA_W-1:0] D,
  input  logic [DATA_W-1:0] Q
);

  logic              w_gnt0;
  logic              w_gnt1;
  logic              w_rd_gnt;
  logic              w_rd_port;

  logic              r_ce_n;
  logic              r_bwe_n;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;

  // Read tracking: stage 1 = SRAM access cycle, stage 2 = data return cycle.
  logic              r_s1_vld;
  logic              r_s1_port;
  logic              r_s2_vld;
  logic              r_s2_port;

`ifdef SRAM_ARB_RR_EN
  // 1 = port 1 was granted most recently; reset makes port 1 win the first tie.
  logic              r_last;

  // Remember the most recently granted port; only moves on a grant.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_last <= 1'b0;
    end else if (w_gnt0 || w_gnt1) begin
      r_last <= w_gnt1;
    end
  end

  // Round-robin grant: on a tie the port not granted most recently wins.
  always_comb begin
    w_gnt1 = 1'b0;
    w_gnt0 = 1'b0;
    if (!RST) begin
      w_gnt1 = req1 && (!req0 || !r_last);
      w_gnt0 = req0 && !w_gnt1;
    end
  end
`else
  // Fixed-priority grant: data port (1) always wins a tie.
  always_comb begin
    w_gnt1 = 1'b0;
    w_gnt0 = 1'b0;
    if (!RST) begin
      w_gnt1 = req1;
      w_gnt0 = req0 && !req1;
    end
  end
`endif

  assign w_rd_gnt  = (w_gnt0 && !we0) || (w_gnt1 && !we1);
  assign w_rd_port = w_gnt1;

  // Launch the granted access onto the SRAM pins; A/D hold when idle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_ce_n  <= 1'b1;
      r_bwe_n <= 1'b1;
      r_addr  <= '0;
      r_data  <= '0;
    end else if (w_gnt1) begin
      r_ce_n  <= 1'b0;
      r_bwe_n <= ~we1;
      r_addr  <= addr1;
      r_data  <= wdata1;
    end else if (w_gnt0) begin
      r_ce_n  <= 1'b0;
      r_bwe_n <= ~we0;
      r_addr  <= addr0;
      r_data  <= wdata0;
    end else begin
      r_ce_n  <= 1'b1;
      r_bwe_n <= 1'b1;
    end
  end

  // Two-stage read tracker; reset drops any reads that are in flight.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_s1_vld  <= 1'b0;
      r_s1_port <= 1'b0;
      r_s2_vld  <= 1'b0;
      r_s2_port <= 1'b0;
    end else begin
      r_s1_vld  <= w_rd_gnt;
      r_s1_port <= w_rd_port;
      r_s2_vld  <= r_s1_vld;
      r_s2_port <= r_s1_port;
    end
  end

  assign gnt0    = w_gnt0;
  assign gnt1    = w_gnt1;
  assign rvalid0 = r_s2_vld && !r_s2_port;
  assign rvalid1 = r_s2_vld &&  r_s2_port;
  assign rdata0  = Q;
  assign rdata1  = Q;
  assign CE_n    = r_ce_n;
  assign BWE_n   = r_bwe_n;
  assign A       = r_addr;
  assign D       = r_data;

endmodule
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_arbiter
// Purpose  : Self-checking bench for sram_arbiter with a behavioural SRAM.
//            Grant vectors come from a table; read data is checked through a
//            scoreboard queue holding {port, data, due cycle}.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_arbiter;

  localparam int AW = 15;
  localparam int DW = 32;

  logic          CLK;
  logic          RST;
  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  logic          CE_n, BWE_n;
  logic [AW-1:0] A;
  logic [DW-1:0] D;
  logic [DW-1:0] Q;

  sram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .CLK(CLK), .RST(RST),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .CE_n(CE_n), .BWE_n(BWE_n), .A(A), .D(D), .Q(Q)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Preload contents of every SRAM word that has not been written yet.
  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    if (a == 15'h0012) return 32'hDEADBEEF;
    return ({17'h0, a} * 32'h0100_0193) ^ 32'hA5C3_0000;
  endfunction

  // Behavioural synchronous SRAM: samples on CLK, read data one cycle later.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  bit            wr  [0:(1<<AW)-1];
  always @(posedge CLK) begin
    if (!CE_n) begin
      if (!BWE_n) begin
        mem[A] <= D;
        wr[A]  <= 1'b1;
      end else begin
        Q <= wr[A] ? mem[A] : init_val(A);
      end
    end
  end

  typedef struct {
    logic          r0, r1, w0, w1;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1;
    logic          eg0, eg1;
  } vec_t;

  typedef struct {
    bit            port;
    logic [DW-1:0] data;
    int            due;
  } sb_t;

  sb_t           sbq [$];
  logic [DW-1:0] ref_mem [int];
  int            n_pass = 0;
  int            n_total = 0;
  int            cyc = 0;
  logic          exp_ce_n, exp_bwe_n;
  logic [AW-1:0] exp_a;
  logic [DW-1:0] exp_d;

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return init_val(a);
  endfunction

  function automatic vec_t mk(input logic r0, r1, w0, w1,
                              input logic [AW-1:0] a0, a1,
                              input logic [DW-1:0] d0, d1,
                              input logic eg0, eg1);
    vec_t v;
    v.r0 = r0; v.r1 = r1; v.w0 = w0; v.w1 = w1;
    v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
    v.eg0 = eg0; v.eg1 = eg1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle=%0d actual=0x%0h expected=0x%0h", name, cyc, act, exp);
  endtask

  task automatic fail_now(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_total++;
    $display("FAIL %s cycle=%0d actual=0x%0h expected=0x%0h", name, cyc, act, exp);
  endtask

  task automatic reset_model();
    exp_ce_n  = 1'b1;
    exp_bwe_n = 1'b1;
    exp_a     = '0;
    exp_d     = '0;
    sbq.delete();
  endtask

  // Read-return scoreboard: every rvalid must match the oldest queued read.
  task automatic check_rvalid();
    sb_t e;
    chk("rvalid_both", {31'h0, rvalid0 & rvalid1}, 32'h0);
    if (rvalid0 || rvalid1) begin
      if (sbq.size() == 0) begin
        fail_now("rvalid_unexpected", {30'h0, rvalid1, rvalid0}, 32'h0);
      end else begin
        e = sbq.pop_front();
        chk("rvalid_port", {31'h0, rvalid1}, {31'h0, e.port});
        chk("rdata", rvalid1 ? rdata1 : rdata0, e.data);
        chk("rvalid_cycle", cyc, e.due);
      end
    end else if (sbq.size() != 0 && sbq[0].due <= cyc) begin
      e = sbq.pop_front();
      fail_now("rvalid_missing", 32'h0, {31'h0, e.port});
    end
  endtask

  // One clock cycle: drive inputs, check at the falling edge, advance model.
  task automatic run_cycle(input vec_t v);
    req0 = v.r0; req1 = v.r1; we0 = v.w0; we1 = v.w1;
    addr0 = v.a0; addr1 = v.a1; wdata0 = v.d0; wdata1 = v.d1;
    @(negedge CLK);
    chk("gnt0", {31'h0, gnt0}, {31'h0, v.eg0});
    chk("gnt1", {31'h0, gnt1}, {31'h0, v.eg1});
    chk("CE_n", {31'h0, CE_n}, {31'h0, exp_ce_n});
    chk("BWE_n", {31'h0, BWE_n}, {31'h0, exp_bwe_n});
    chk("A", {17'h0, A}, {17'h0, exp_a});
    chk("D", D, exp_d);
    check_rvalid();
    if (v.eg1 || v.eg0) begin
      logic          we;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      we = v.eg1 ? v.w1 : v.w0;
      a  = v.eg1 ? v.a1 : v.a0;
      d  = v.eg1 ? v.d1 : v.d0;
      exp_ce_n  = 1'b0;
      exp_bwe_n = ~we;
      exp_a     = a;
      exp_d     = d;
      if (we) ref_mem[int'(a)] = d;
      else    sbq.push_back('{port: v.eg1, data: ref_rd(a), due: cyc + 2});
    end else begin
      exp_ce_n  = 1'b1;
      exp_bwe_n = 1'b1;
    end
    cyc++;
    @(posedge CLK);
    #1;
  endtask

  vec_t tv [25];
  logic tie_b, tie_d;

  initial begin
    #100000;
    $display("FAIL watchdog cycle=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    RST = 1'b1;
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
    addr0 = 15'h1234; addr1 = 15'h0567; wdata0 = 32'h1111_1111; wdata1 = 32'h2222_2222;
    reset_model();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_gnt0", {31'h0, gnt0}, 32'h0);
    chk("rst_gnt1", {31'h0, gnt1}, 32'h0);
    chk("rst_rvalid0", {31'h0, rvalid0}, 32'h0);
    chk("rst_rvalid1", {31'h0, rvalid1}, 32'h0);
    chk("rst_CE_n", {31'h0, CE_n}, 32'h1);
    chk("rst_BWE_n", {31'h0, BWE_n}, 32'h1);
    chk("rst_A", {17'h0, A}, 32'h0);
    chk("rst_D", D, 32'h0);
    @(posedge CLK);
    #1;
    RST = 1'b0;

`ifdef SRAM_ARB_RR_EN
    tie_b = 1'b0;  // round robin alternates back to port 0
    tie_d = 1'b0;
`else
    tie_b = 1'b1;  // fixed priority keeps port 1
    tie_d = 1'b1;
`endif
    //            r0 r1 w0 w1  a0       a1       d0            d1            g0 g1
    tv[0]  = mk(1, 0, 0, 0, 15'h0012, 15'h0000, 32'h0,        32'h0,        1, 0);
    tv[1]  = mk(0, 0, 0, 0, 15'h0000, 15'h0000, 32'h0,        32'h0,        0, 0);
    tv[2]  = mk(0, 0, 0, 0, 15'h0000, 15'h0000, 32'h0,        32'h0,        0, 0);
    tv[3]  = mk(0, 1, 0, 1, 15'h0000, 15'h7FFF, 32'h0,        32'h12345678, 0, 1);
    tv[4]  = mk(0, 1, 0, 0, 15'h0000, 15'h7FFF, 32'h0,        32'h0,        0, 1);
    tv[5]  = mk(0, 0, 0, 0, 15'h0000, 15'h0000, 32'h0,        32'h0,        0, 0);
    tv[6]  = mk(0, 0, 0, 0, 15'h0000, 15'h0000, 32'h0,        32'h0,        0, 0);
    tv[7]  = mk(1, 0, 0, 0, 15'h0050, 15'h0000, 32'h0,        32'h0,        1, 0);
    tv[8]  = mk(1, 1, 0, 0, 15'h0100, 15'h0200, 32'h0,        32'h0,        0, 1);
    tv[9]  = mk(1, 1, 0, 0, 15'h0100, 15'h0201, 32'h0,        32'h0,        !tie_b, tie_b);
    tv[10] = mk(1, 1, 0, 0, 15'h0100, 15'h0202, 32'h0,        32'h0,        0, 1);
    tv[11] = mk(1, 1, 0, 0, 15'h0100, 15'h0203, 32'h0,        32'h0,        !tie_d, tie_d);
    tv[12] = mk(1, 0, 0, 0, 15'h0101, 15'h0000, 32'h0,        32'h0,        1, 0);
    tv[13] = mk(1, 1, 1, 0, 15'h0400, 15'h0400, 32'hA5A5A5A5, 32'h0,        0, 1);
    tv[14] = mk(1, 0, 1, 0, 15'h0400, 15'h0000, 32'hA5A5A5A5, 32'h0,        1, 0);
    tv[15] = mk(0, 1, 0, 0, 15'h0000, 15'h0400, 32'h0,        32'h0,        0, 1);
    tv[16] = mk(1, 0, 0, 0, 15'h0300, 15'h0000, 32'h0,        32'h0,        1, 0);
    tv[17] = mk(1, 0, 0, 0, 15'h0301, 15'h0000, 32'h0,        32'h0,        1, 0);
    tv[18] = mk(1, 0, 0, 0, 15'h0302, 15'h0000, 32'h0,        32'h0,        1, 0);
    tv[19] = mk(0, 1, 0, 0, 15'h0000, 15'h0012, 32'h0,        32'h0,        0, 1);
    tv[20] = mk(1, 0, 0, 0, 15'h7FFF, 15'h0000, 32'h0,        32'h0,        1, 0);
    tv[21] = mk(0, 1, 0, 0, 15'h0000, 15'h0050, 32'h0,        32'h0,        0, 1);
    tv[22] = mk(0, 0, 0, 0, 15'h0000, 15'h0000, 32'h0,        32'h0,        0, 0);
    tv[23] = mk(0, 0, 0, 0, 15'h0000, 15'h0000, 32'h0,        32'h0,        0, 0);
    tv[24] = mk(0, 0, 0, 0, 15'h0000, 15'h0000, 32'h0,        32'h0,        0, 0);

    for (int i = 0; i < 25; i++) run_cycle(tv[i]);

    // Idle: inputs wiggle without requests; SRAM pins must stay parked.
    for (int i = 0; i < 10; i++) begin
      run_cycle(mk(0, 0, i[0], i[1], 15'($urandom), 15'($urandom),
                   $urandom, $urandom, 0, 0));
    end

    // Reset while a read is in flight: the read must never return.
    run_cycle(mk(1, 0, 0, 0, 15'h0012, 15'h0000, 32'h0, 32'h0, 1, 0));
    RST = 1'b1;
    req0 = 1'b1;
    #1;
    chk("midrst_CE_n", {31'h0, CE_n}, 32'h1);
    chk("midrst_A", {17'h0, A}, 32'h0);
    chk("midrst_gnt0", {31'h0, gnt0}, 32'h0);
    reset_model();
    @(negedge CLK);
    check_rvalid();
    cyc++;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    for (int i = 0; i < 3; i++) run_cycle(mk(0, 0, 0, 0, 15'h0, 15'h0, 32'h0, 32'h0, 0, 0));
    chk("sb_drained", sbq.size(), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
